// File: rtl/swg_window_collector.sv
// Purpose : reassembles ELEM_PER_WINDOW consecutive element beats into one wide window word.
// Latency : window valid one cycle after its last element is accepted; one beat per cycle sustained.
// Backpr. : only the last element of a window is stalled, and only while the output is held.
// Option  : define SWG_COLLECTOR_TLAST_EN to add out_V_V_TLAST and the window-per-frame counter.
module swg_window_collector #(
    parameter int BIT_WIDTH         = 4,
    parameter int SIMD              = 1,
    parameter int ELEM_PER_WINDOW   = 9,
    parameter int WINDOWS_PER_FRAME = 144
) (
    input  logic                                      ap_clk,
    input  logic                                      ap_rst_n,
    input  logic                                      in0_V_V_TVALID,
    output logic                                      in0_V_V_TREADY,
    input  logic [BIT_WIDTH*SIMD-1:0]                 in0_V_V_TDATA,
    output logic                                      out_V_V_TVALID,
    input  logic                                      out_V_V_TREADY,
    output logic [BIT_WIDTH*SIMD*ELEM_PER_WINDOW-1:0] out_V_V_TDATA
`ifdef SWG_COLLECTOR_TLAST_EN
    ,
    output logic                                      out_V_V_TLAST
`endif
);

    localparam int EW    = BIT_WIDTH * SIMD;
    localparam int OW    = EW * ELEM_PER_WINDOW;
    localparam int POS_W = (ELEM_PER_WINDOW > 1) ? $clog2(ELEM_PER_WINDOW) : 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(ELEM_PER_WINDOW - 1);

    // Reject configurations that cannot form a window or a frame.
    if (ELEM_PER_WINDOW < 1 || WINDOWS_PER_FRAME < 1) begin : g_cfg_err
        $error("swg_window_collector: ELEM_PER_WINDOW and WINDOWS_PER_FRAME must be >= 1");
    end

    logic [POS_W-1:0] pos_q, pos_d;
    logic [OW-1:0]    out_dat_q, out_dat_d;
    logic             out_vld_q, out_vld_d;
    logic [OW-1:0]    new_win;
    logic             last_beat;
    logic             in_acc;
    logic             out_acc;
    logic             in_rdy;

    assign last_beat = (pos_q == LAST_POS);
    assign out_acc   = out_vld_q && out_V_V_TREADY;
    // Output slot is free when empty or being drained this cycle; non-last beats never wait.
    assign in_rdy    = ap_rst_n && (!last_beat || !out_vld_q || out_V_V_TREADY);
    assign in_acc    = in0_V_V_TVALID && in_rdy;

    assign in0_V_V_TREADY = in_rdy;
    assign out_V_V_TVALID = out_vld_q;
    assign out_V_V_TDATA  = out_dat_q;

    if (ELEM_PER_WINDOW > 1) begin : g_asm
        logic [EW*(ELEM_PER_WINDOW-1)-1:0] asm_q, asm_d;

        // Park each non-last element at its slot; the last one bypasses straight into the output.
        always_comb begin
            asm_d = asm_q;
            if (in_acc && !last_beat) begin
                asm_d[int'(pos_q)*EW +: EW] = in0_V_V_TDATA;
            end
        end

        // Assembly register; contents are discarded on reset.
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                asm_q <= '0;
            end else begin
                asm_q <= asm_d;
            end
        end

        assign new_win = {in0_V_V_TDATA, asm_q};
    end else begin : g_no_asm
        assign new_win = in0_V_V_TDATA;
    end

    // Element position and output slot next state; a load wins over a drain so nothing is lost.
    always_comb begin
        pos_d     = pos_q;
        out_dat_d = out_dat_q;
        out_vld_d = out_vld_q;
        if (in_acc) begin
            pos_d = last_beat ? '0 : pos_q + POS_W'(1);
        end
        if (in_acc && last_beat) begin
            out_dat_d = new_win;
            out_vld_d = 1'b1;
        end else if (out_acc) begin
            out_vld_d = 1'b0;
        end
    end

    // Position counter and output register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pos_q     <= '0;
            out_dat_q <= '0;
            out_vld_q <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            out_dat_q <= out_dat_d;
            out_vld_q <= out_vld_d;
        end
    end

`ifdef SWG_COLLECTOR_TLAST_EN
    localparam int WIN_W = (WINDOWS_PER_FRAME > 1) ? $clog2(WINDOWS_PER_FRAME) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOWS_PER_FRAME - 1);

    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic             tlast_q, tlast_d;

    // Count completed windows; TLAST travels with the window it marks.
    always_comb begin
        win_cnt_d = win_cnt_q;
        tlast_d   = tlast_q;
        if (in_acc && last_beat) begin
            tlast_d   = (win_cnt_q == WIN_LAST);
            win_cnt_d = (win_cnt_q == WIN_LAST) ? '0 : win_cnt_q + WIN_W'(1);
        end
    end

    // Window counter and TLAST register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            win_cnt_q <= '0;
            tlast_q   <= 1'b0;
        end else begin
            win_cnt_q <= win_cnt_d;
            tlast_q   <= tlast_d;
        end
    end

    assign out_V_V_TLAST = tlast_q;
`endif

endmodule

// File: tb/tb_swg_window_collector.sv
// Self-checking bench for swg_window_collector: a 9-element instance and a 1-element instance,
// both against a queue-based model of accepted beats and delivered windows.
module tb_swg_window_collector;

    localparam int EW  = 4;
    localparam int EPW = 9;
    localparam int WPF = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic                a_vld, a_rdy, a_ovld, a_ordy;
    logic [EW-1:0]       a_dat;
    logic [EW*EPW-1:0]   a_odat;
    logic                b_vld, b_rdy, b_ovld, b_ordy;
    logic [EW-1:0]       b_dat;
    logic [EW-1:0]       b_odat;
`ifdef SWG_COLLECTOR_TLAST_EN
    logic                a_olast, b_olast;
`endif

    swg_window_collector #(
        .BIT_WIDTH(4), .SIMD(1), .ELEM_PER_WINDOW(EPW), .WINDOWS_PER_FRAME(WPF)
    ) dut_a (
        .ap_clk         (clk),
        .ap_rst_n       (rst_n),
        .in0_V_V_TVALID (a_vld),
        .in0_V_V_TREADY (a_rdy),
        .in0_V_V_TDATA  (a_dat),
        .out_V_V_TVALID (a_ovld),
        .out_V_V_TREADY (a_ordy),
        .out_V_V_TDATA  (a_odat)
`ifdef SWG_COLLECTOR_TLAST_EN
        ,
        .out_V_V_TLAST  (a_olast)
`endif
    );

    swg_window_collector #(
        .BIT_WIDTH(4), .SIMD(1), .ELEM_PER_WINDOW(1), .WINDOWS_PER_FRAME(WPF)
    ) dut_b (
        .ap_clk         (clk),
        .ap_rst_n       (rst_n),
        .in0_V_V_TVALID (b_vld),
        .in0_V_V_TREADY (b_rdy),
        .in0_V_V_TDATA  (b_dat),
        .out_V_V_TVALID (b_ovld),
        .out_V_V_TREADY (b_ordy),
        .out_V_V_TDATA  (b_odat)
`ifdef SWG_COLLECTOR_TLAST_EN
        ,
        .out_V_V_TLAST  (b_olast)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: accepted beats not yet delivered, and window counts.
    logic [EW-1:0]     qa[$];
    logic [EW-1:0]     qb[$];
    int                acc_a, taken_a, acc_b, taken_b;
    logic              stall_a, stall_b;
    logic [EW*EPW-1:0] prev_a;
    logic [EW-1:0]     prev_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        qa.delete();
        qb.delete();
        acc_a = 0; taken_a = 0; acc_b = 0; taken_b = 0;
        stall_a = 1'b0; stall_b = 1'b0;
        prev_a = '0; prev_b = '0;
    endtask

    // One clock of the 9-element instance: drive, check against the model, update the model.
    task automatic cyc_a(input logic v, input logic [EW-1:0] d, input logic r);
        logic              exp_v;
        logic [EW*EPW-1:0] w;
        w = '0;
        a_vld = v; a_dat = d; a_ordy = r;
        #1;
        exp_v = ((acc_a / EPW) != taken_a);
        check("a_tvalid", 64'(a_ovld), 64'(exp_v));
        check("a_tready", 64'(a_rdy), 64'(!(((acc_a % EPW) == EPW - 1) && exp_v && !r)));
        if (stall_a && a_ovld) check("a_hold", 64'(a_odat), 64'(prev_a));
        if (a_ovld && r) begin
            if (qa.size() < EPW) begin
                check("a_underflow", 64'(qa.size()), 64'(EPW));
            end else begin
                for (int k = 0; k < EPW; k++) w[k*EW +: EW] = qa.pop_front();
                check("a_window", 64'(a_odat), 64'(w));
            end
`ifdef SWG_COLLECTOR_TLAST_EN
            check("a_tlast", 64'(a_olast), 64'((taken_a % WPF) == WPF - 1));
`endif
            taken_a++;
        end
        if (v && a_rdy) begin
            qa.push_back(d);
            acc_a++;
        end
        stall_a = a_ovld && !r;
        prev_a  = a_odat;
        @(negedge clk);
    endtask

    // One clock of the 1-element instance.
    task automatic cyc_b(input logic v, input logic [EW-1:0] d, input logic r);
        logic          exp_v;
        logic [EW-1:0] w;
        b_vld = v; b_dat = d; b_ordy = r;
        #1;
        exp_v = (acc_b != taken_b);
        check("b_tvalid", 64'(b_ovld), 64'(exp_v));
        check("b_tready", 64'(b_rdy), 64'(!(exp_v && !r)));
        if (stall_b && b_ovld) check("b_hold", 64'(b_odat), 64'(prev_b));
        if (b_ovld && r) begin
            if (qb.size() == 0) begin
                check("b_underflow", 64'(qb.size()), 64'(1));
            end else begin
                w = qb.pop_front();
                check("b_data", 64'(b_odat), 64'(w));
            end
`ifdef SWG_COLLECTOR_TLAST_EN
            check("b_tlast", 64'(b_olast), 64'((taken_b % WPF) == WPF - 1));
`endif
            taken_b++;
        end
        if (v && b_rdy) begin
            qb.push_back(d);
            acc_b++;
        end
        stall_b = b_ovld && !r;
        prev_b  = b_odat;
        @(negedge clk);
    endtask

    // Reset both instances (entered and left on a falling edge) and check reset values.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_a_tvalid", 64'(a_ovld), 64'(0));
        check("rst_a_tready", 64'(a_rdy), 64'(0));
        check("rst_a_tdata",  64'(a_odat), 64'(0));
        check("rst_b_tvalid", 64'(b_ovld), 64'(0));
        check("rst_b_tready", 64'(b_rdy), 64'(0));
`ifdef SWG_COLLECTOR_TLAST_EN
        check("rst_a_tlast", 64'(a_olast), 64'(0));
`endif
        @(negedge clk);
        @(negedge clk);
        clear_model();
        rst_n = 1'b1;
    endtask

    initial begin
        int            base;
        logic [EW-1:0] d9;
        rst_n = 1'b0;
        a_vld = 1'b0; a_dat = '0; a_ordy = 1'b0;
        b_vld = 1'b0; b_dat = '0; b_ordy = 1'b0;
        clear_model();
        @(negedge clk);
        do_reset();

        // Data ordering: elements 1..9 form 0x987654321, valid for exactly one cycle.
        for (int i = 1; i <= 9; i++) cyc_a(1'b1, EW'(i), 1'b1);
        #1;
        check("order_tvalid", 64'(a_ovld), 64'(1));
        check("order_tdata", 64'(a_odat), 64'h987654321);
        cyc_a(1'b0, '0, 1'b1);
        cyc_a(1'b0, '0, 1'b1);

        // Throughput: four windows back-to-back, both sides always ready.
        base = taken_a;
        for (int i = 0; i < 4 * EPW; i++) cyc_a(1'b1, EW'($urandom), 1'b1);
        cyc_a(1'b0, '0, 1'b1);
        check("thru_windows", 64'(taken_a - base), 64'(4));

        // Stall: window 1 held, window 2 fills to its last element, then both drain.
        for (int i = 0; i < EPW; i++) cyc_a(1'b1, EW'($urandom), 1'b0);
        base = acc_a;
        for (int i = 0; i < EPW - 1; i++) cyc_a(1'b1, EW'($urandom), 1'b0);
        check("stall_absorbed", 64'(acc_a - base), 64'(EPW - 1));
        d9 = EW'($urandom);
        repeat (3) cyc_a(1'b1, d9, 1'b0);
        check("stall_blocked", 64'(acc_a - base), 64'(EPW - 1));
        cyc_a(1'b1, d9, 1'b1);
        check("stall_last_taken", 64'(acc_a - base), 64'(EPW));
        cyc_a(1'b0, '0, 1'b1);
        cyc_a(1'b0, '0, 1'b1);
        check("stall_drained", 64'(taken_a * EPW), 64'(acc_a));

        // Reset mid-window: partial window discarded, next nine beats form a clean window.
        for (int i = 0; i < 5; i++) cyc_a(1'b1, EW'($urandom), 1'b1);
        do_reset();
        for (int i = 0; i < EPW; i++) cyc_a(1'b1, EW'($urandom), 1'b1);
        cyc_a(1'b0, '0, 1'b1);
        check("rst_mid_windows", 64'(taken_a), 64'(1));

        // Frame: eight windows streamed from a fresh reset (TLAST on windows 4 and 8).
        do_reset();
        for (int i = 0; i < 8 * EPW; i++) cyc_a(1'b1, EW'($urandom), 1'b1);
        cyc_a(1'b0, '0, 1'b1);
        check("frame_windows", 64'(taken_a), 64'(8));

        // Random valid/ready on both sides.
        for (int i = 0; i < 400; i++)
            cyc_a(1'($urandom_range(0, 3) != 0), EW'($urandom), 1'($urandom_range(0, 2) != 0));
        repeat (3) cyc_a(1'b0, '0, 1'b1);
        check("rand_a_drained", 64'(taken_a), 64'(acc_a / EPW));
        a_vld = 1'b0; a_ordy = 1'b0;

        // One-element windows: random stream with downstream ready alternating 1/0.
        do_reset();
        for (int i = 0; i < 200; i++)
            cyc_b(1'($urandom_range(0, 3) != 0), EW'($urandom), 1'(i % 2 == 0));
        repeat (3) cyc_b(1'b0, '0, 1'b1);
        check("b_no_loss", 64'(taken_b), 64'(acc_b));
        check("b_queue_empty", 64'(qb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
